// File: rtl/column_corr_pkg.sv
// Shared definitions for the column-correction LUT controller: FSM state
// encoding and construction of the unity-gain / zero-offset default word.
package column_corr_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PENDING = 2'd2
  } lut_state_e;

  localparam int MAX_WORD_BITS = 1024;

  // One lane is {offset, gain}; unity gain is a single 1 at the binary point.
  function automatic logic [MAX_WORD_BITS-1:0] default_word(
    input int n_lanes,
    input int gain_bits,
    input int gain_frac_bits,
    input int offset_bits
  );
    logic [MAX_WORD_BITS-1:0] w;
    w = '0;
    for (int i = 0; i < n_lanes; i++) begin
      w[i*(gain_bits+offset_bits)+gain_frac_bits] = 1'b1;
    end
    return w;
  endfunction

endpackage

// File: rtl/lut_bank_ram.sv
// Two-bank table RAM: one synchronous write port that can hit either or both
// banks, one asynchronous read port selected by bank index.
module lut_bank_ram #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 64
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic                 wr_both,
  input  logic                 wr_bank,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_bank,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  localparam int DEPTH = 2**ADDR_BITS;

  logic [DATA_BITS-1:0] bank0 [DEPTH];
  logic [DATA_BITS-1:0] bank1 [DEPTH];

  // NOTE: the arrays have no reset; the controller's INIT sweep fills them,
  // which keeps them mappable onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_both || !wr_bank)) bank0[wr_addr] <= wr_data;
    if (wr_en && (wr_both ||  wr_bank)) bank1[wr_addr] <= wr_data;
  end

  assign rd_data = rd_bank ? bank1[rd_addr] : bank0[rd_addr];

endmodule

// File: rtl/column_lut_ctrl.sv
// Double-buffered per-column gain/offset LUT: the host fills the shadow bank,
// a commit arms a swap that takes effect only on a frame boundary.
module column_lut_ctrl
  import column_corr_pkg::*;
#(
  parameter int WIDTH_BITS     = 10,
  parameter int N              = 4,
  parameter int GAIN_BITS      = 8,
  parameter int GAIN_FRAC_BITS = 7,
  parameter int OFFSET_BITS    = 8,
  parameter int LUT_DATA_BITS  = (GAIN_BITS + OFFSET_BITS) * N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_wr_en,
  input  logic [WIDTH_BITS-1:0]    cfg_addr,
  input  logic [LUT_DATA_BITS-1:0] cfg_wdata,
  input  logic                     cfg_commit,
  output logic                     cfg_ready,
  input  logic                     valid_i,
  input  logic                     eof_i,
  input  logic [WIDTH_BITS-1:0]    lut_raddr,
  output logic [LUT_DATA_BITS-1:0] lut_rdata,
  output logic                     active_bank,
  output logic                     swap_done
);

  localparam logic [WIDTH_BITS-1:0] LAST_ADDR = '1;
  localparam logic [LUT_DATA_BITS-1:0] DEF_WORD =
    LUT_DATA_BITS'(default_word(N, GAIN_BITS, GAIN_FRAC_BITS, OFFSET_BITS));

  lut_state_e              state_q, state_d;
  logic [WIDTH_BITS-1:0]   init_addr_q, init_addr_d;
  logic                    active_bank_q, active_bank_d;
  logic                    swap_done_q, swap_done_d;

  logic                     ram_we, ram_we_both;
  logic [WIDTH_BITS-1:0]    ram_waddr;
  logic [LUT_DATA_BITS-1:0] ram_wdata, ram_rdata;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INIT;
      init_addr_q   <= '0;
      active_bank_q <= 1'b0;
      swap_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_addr_q   <= init_addr_d;
      active_bank_q <= active_bank_d;
      swap_done_q   <= swap_done_d;
    end
  end

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    init_addr_d   = init_addr_q;
    active_bank_d = active_bank_q;
    swap_done_d   = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == LAST_ADDR) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (cfg_commit) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        // Swapping on the eof beat means the next frame's first pixel already
        // reads the new bank, and no frame ever sees a mid-frame change.
        if (valid_i && eof_i) begin
          state_d       = ST_IDLE;
          active_bank_d = ~active_bank_q;
          swap_done_d   = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    cfg_ready   = 1'b0;
    ram_we      = 1'b0;
    ram_we_both = 1'b0;
    ram_waddr   = cfg_addr;
    ram_wdata   = cfg_wdata;
    lut_rdata   = ram_rdata;
    case (state_q)
      ST_INIT: begin
        ram_we      = 1'b1;
        ram_we_both = 1'b1;
        ram_waddr   = init_addr_q;
        ram_wdata   = DEF_WORD;
        lut_rdata   = DEF_WORD;
      end
      ST_IDLE: begin
        cfg_ready = 1'b1;
        ram_we    = cfg_wr_en;
      end
      default: ;
    endcase
  end

  assign active_bank = active_bank_q;
  assign swap_done   = swap_done_q;

  lut_bank_ram #(
    .ADDR_BITS (WIDTH_BITS),
    .DATA_BITS (LUT_DATA_BITS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_both (ram_we_both),
    .wr_bank (~active_bank_q),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_bank (active_bank_q),
    .rd_addr (lut_raddr),
    .rd_data (ram_rdata)
  );

endmodule

// File: doc/column_lut_ctrl.md
COLUMN_LUT_CTRL -- requirements
Module: column_lut_ctrl

Interface
REQ-001 SHALL have parameter WIDTH_BITS, default 10, meaning LUT address width; table depth is 2**WIDTH_BITS entries.
REQ-002 SHALL have parameter N, default 4, meaning pixels per data word.
REQ-003 SHALL have parameter GAIN_BITS, default 8, meaning gain field width.
REQ-004 SHALL have parameter GAIN_FRAC_BITS, default 7, meaning gain fractional bits.
REQ-005 SHALL have parameter OFFSET_BITS, default 8, meaning offset field width.
REQ-006 SHALL have parameter LUT_DATA_BITS, default (GAIN_BITS+OFFSET_BITS)*N, meaning LUT word width; entry i holds gain at bits [16i+7:16i] and offset at bits [16i+15:16i+8] for the defaults.
REQ-007 SHALL use one clock and an asynchronous, active-high reset.
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-010 SHALL have port cfg_wr_en, input, 1 bit: host write strobe.
REQ-011 SHALL have port cfg_addr, input, WIDTH_BITS: host write column index.
REQ-012 SHALL have port cfg_wdata, input, LUT_DATA_BITS: host write word.
REQ-013 SHALL have port cfg_commit, input, 1 bit: one-cycle request to activate the shadow table.
REQ-014 SHALL have port cfg_ready, output, 1 bit: host writes and commits are accepted.
REQ-015 SHALL have port valid_i, input, 1 bit: pixel-stream valid, tapped from the correction input.
REQ-016 SHALL have port eof_i, input, 1 bit: end-of-frame, qualified by valid_i.
REQ-017 SHALL have port lut_raddr, input, WIDTH_BITS: read address from the correction datapath.
REQ-018 SHALL have port lut_rdata, output, LUT_DATA_BITS: gain/offset word for the correction datapath.
REQ-019 SHALL have port active_bank, output, 1 bit: index of the bank currently being read.
REQ-020 SHALL have port swap_done, output, 1 bit: one-cycle pulse on the cycle after a bank swap.

Function
REQ-021 SHALL hold two table banks; the active bank is read and the other (shadow) bank is written.
REQ-022 SHALL drive lut_rdata combinationally from active bank[lut_raddr], with zero-cycle latency.
REQ-023 SHALL implement the states INIT, IDLE and PENDING.
REQ-024 SHALL, in INIT, write the default word to address k of both banks on cycle k, for k = 0..2**WIDTH_BITS-1, then enter IDLE.
REQ-025 SHALL use as default word gain = 1<<GAIN_FRAC_BITS and offset = 0 in every pixel lane (0x0080 per lane for the defaults).
REQ-026 SHALL force lut_rdata to the default word during INIT.
REQ-027 SHALL drive cfg_ready = 1 only in IDLE; cfg_wr_en and cfg_commit SHALL be ignored whenever cfg_ready = 0.
REQ-028 SHALL, in IDLE, write cfg_wdata to shadow[cfg_addr] when cfg_wr_en = 1; the write is visible to reads after the swap only.
REQ-029 SHALL, in IDLE with cfg_commit = 1, enter PENDING on the next cycle; a write in the same cycle as the commit SHALL be performed.
REQ-030 SHALL, in PENDING, toggle active_bank, pulse swap_done one cycle later, and return to IDLE when valid_i & eof_i.
REQ-031 SHALL not swap on an eof_i that occurs in the same cycle as the commit; that swap SHALL wait for the next eof.
REQ-032 SHALL never change active_bank within a frame.
REQ-033 SHALL not copy tables after a swap; the new shadow bank holds the previous table, and the host rewrites every entry it needs.

Reset
REQ-034 SHALL, on rst assertion at any time, go to INIT asynchronously with active_bank = 0, swap_done = 0 and cfg_ready = 0.
REQ-035 SHALL restart the INIT sweep from address 0 after a mid-operation reset, discarding any pending commit.

Structure
REQ-036 SHALL place the state encoding (INIT/IDLE/PENDING) and the default-word construction function in a shared package column_corr_pkg.
REQ-037 SHALL implement the banks as one sub-module, lut_bank_ram: a dual-bank RAM with one synchronous write port and one asynchronous read port.

Verification
REQ-038 SHALL verify reset: after reset, cfg_ready = 0 for exactly 1024 cycles, lut_rdata = 0x0080008000800080 at any address, and active_bank = 0.
REQ-039 SHALL verify shadow isolation: writing 0x0101... to address 5 in IDLE leaves the read at address 5 at the default word until a swap occurs.
REQ-040 SHALL verify swap: commit, then valid_i & eof_i three frames later -> active_bank = 1, swap_done pulses once, the read at address 5 returns 0x0101..., and cfg_ready returns to 1.
REQ-041 SHALL verify the simultaneous case: commit and eof in the same cycle -> no swap, and the swap occurs at the following eof.
REQ-042 SHALL verify ignored input: cfg_wr_en during PENDING to address 7 -> shadow[7] remains unchanged after the swap back.
REQ-043 SHALL verify reset mid-PENDING: rst asserted -> INIT restarts, and after 1024 cycles active_bank = 0, every read returns the default word, and no swap_done pulse occurs.
